// File: rtl/lcd_controller.sv
// LCD power-on/configuration sequencer and command front end.
// After reset it waits for the panel supply, drives the four-bit wake-up
// nibbles directly on the LCD pins, issues the four configuration words
// through the instruction FSM, and then accepts user commands one at a time.
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SHORT   = 2000,
  parameter int T_E_HIGH  = 12,
  parameter int T_CLEAR   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic [9:0] instr_data,
  output logic       instr_enable,
  input  logic       instr_done,
  output logic       init_active,
  output logic [3:0] init_nibble,
  output logic       init_lcd_e
);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CFG_ISSUE, CFG_WAIT, IDLE, CMD_WAIT, LONG_DELAY
  } state_t;

  // Terminal counts: a wait of N cycles ends when the counter reads N-1.
  // INIT_NIB spans 2 setup cycles plus the E-high window.
  localparam logic [19:0] TC_PWR   = 20'(T_POWERUP - 1);
  localparam logic [19:0] TC_NIB   = 20'(T_E_HIGH + 1);
  localparam logic [19:0] TC_INIT1 = 20'(T_INIT1 - 1);
  localparam logic [19:0] TC_INIT2 = 20'(T_INIT2 - 1);
  localparam logic [19:0] TC_SHORT = 20'(T_SHORT - 1);
  localparam logic [19:0] TC_CLEAR = 20'(T_CLEAR - 1);

  state_t      state, state_next;
  logic [19:0] cnt, cnt_next;
  logic [1:0]  nib_idx, nib_idx_next;
  logic [1:0]  cfg_idx, cfg_idx_next;

  logic       cmd_ready_next, init_done_next, instr_enable_next;
  logic       init_active_next, init_lcd_e_next;
  logic [9:0] instr_data_next;
  logic [3:0] init_nibble_next;

  logic done_ok;
  logic long_cmd;
  logic accept;

  function automatic logic [3:0] nib_value(input logic [1:0] idx);
    return (idx == 2'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [19:0] nib_wait_tc(input logic [1:0] idx);
    case (idx)
      2'd0:    return TC_INIT1;
      2'd1:    return TC_INIT2;
      default: return TC_SHORT;
    endcase
  endfunction

  function automatic logic [9:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 10'h028;
      2'd1:    return 10'h006;
      2'd2:    return 10'h00C;
      default: return 10'h001;
    endcase
  endfunction

  // A completion in the same cycle as the enable pulse is stale and ignored.
  assign done_ok  = instr_done && !instr_enable;
  // Clear display / return home need the extra settling delay (RW is a don't-care).
  assign long_cmd = !instr_data[9] && (instr_data[7:2] == 6'd0) && (instr_data[1:0] != 2'd0);
  assign accept   = (state == IDLE) && cmd_valid && cmd_ready;

  // State, delay counter and sequence indices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= PWR_WAIT;
      cnt     <= '0;
      nib_idx <= '0;
      cfg_idx <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      nib_idx <= nib_idx_next;
      cfg_idx <= cfg_idx_next;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_next   = state;
    nib_idx_next = nib_idx;
    cfg_idx_next = cfg_idx;
    case (state)
      PWR_WAIT:
        if (cnt == TC_PWR) begin
          state_next   = INIT_NIB;
          nib_idx_next = 2'd0;
        end
      INIT_NIB:
        if (cnt == TC_NIB) state_next = INIT_WAIT;
      INIT_WAIT:
        if (cnt == nib_wait_tc(nib_idx)) begin
          if (nib_idx == 2'd3) begin
            state_next   = CFG_ISSUE;
            cfg_idx_next = 2'd0;
          end else begin
            state_next   = INIT_NIB;
            nib_idx_next = nib_idx + 2'd1;
          end
        end
      CFG_ISSUE:
        state_next = CFG_WAIT;
      CFG_WAIT:
        if (done_ok) begin
          if (cfg_idx == 2'd3) begin
            state_next = LONG_DELAY;
          end else begin
            state_next   = CFG_ISSUE;
            cfg_idx_next = cfg_idx + 2'd1;
          end
        end
      IDLE:
        if (accept) state_next = CMD_WAIT;
      CMD_WAIT:
        if (done_ok) state_next = long_cmd ? LONG_DELAY : IDLE;
      LONG_DELAY:
        if (cnt == TC_CLEAR) state_next = IDLE;
      default:
        state_next = PWR_WAIT;
    endcase
    cnt_next = (state_next != state) ? 20'd0 : cnt + 20'd1;
  end

  // Output decode from the upcoming state so every output is a flop aligned with its state.
  always_comb begin
    cmd_ready_next    = (state_next == IDLE);
    init_done_next    = init_done || (state_next == IDLE);
    init_active_next  = (state_next == PWR_WAIT) || (state_next == INIT_NIB) ||
                        (state_next == INIT_WAIT);
    init_nibble_next  = ((state_next == INIT_NIB) || (state_next == INIT_WAIT)) ?
                        nib_value(nib_idx_next) : 4'h0;
    init_lcd_e_next   = (state_next == INIT_NIB) && (cnt_next >= 20'd2);
    instr_enable_next = (state_next == CFG_ISSUE) || accept;
    instr_data_next   = instr_data;
    if (state_next == CFG_ISSUE) begin
      instr_data_next = cfg_word(cfg_idx_next);
    end else if (accept) begin
      instr_data_next = cmd_data;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready    <= 1'b0;
      init_done    <= 1'b0;
      instr_enable <= 1'b0;
      instr_data   <= 10'h000;
      init_active  <= 1'b1;
      init_nibble  <= 4'h0;
      init_lcd_e   <= 1'b0;
    end else begin
      cmd_ready    <= cmd_ready_next;
      init_done    <= init_done_next;
      instr_enable <= instr_enable_next;
      instr_data   <= instr_data_next;
      init_active  <= init_active_next;
      init_nibble  <= init_nibble_next;
      init_lcd_e   <= init_lcd_e_next;
    end
  end

endmodule
